exec_unit: RTL and testbench

- Execute stage directly downstream of the 16x16 two-read/one-write register file.
- Consumes the file's a/b read data and produces the write-back triple that returns to the file's d/dest_sel/load_en inputs.
- Runs single-cycle ALU operations and an iterative multi-cycle multiply, with a valid/ready issue handshake.

---
 rtl/exec_pkg.sv | 26 ++
 rtl/exec_if.sv | 28 ++
 rtl/exec_alu.sv | 46 ++++
 rtl/exec_unit.sv | 169 ++++++++++++++++
 tb/tb_exec_unit.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: datapath sizes, opcodes, FSM states.
package exec_pkg;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned SEL_W   = 4;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned SHAMT_W = $clog2(WIDTH);
  localparam int unsigned CNT_W   = $clog2(WIDTH);

  localparam logic [OP_W-1:0] OP_MOV = 4'd0;
  localparam logic [OP_W-1:0] OP_ADD = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB = 4'd2;
  localparam logic [OP_W-1:0] OP_AND = 4'd3;
  localparam logic [OP_W-1:0] OP_OR  = 4'd4;
  localparam logic [OP_W-1:0] OP_XOR = 4'd5;
  localparam logic [OP_W-1:0] OP_NOT = 4'd6;
  localparam logic [OP_W-1:0] OP_SHL = 4'd7;
  localparam logic [OP_W-1:0] OP_SHR = 4'd8;
  localparam logic [OP_W-1:0] OP_MUL = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/exec_if.sv
// Issue handshake and write-back bundle between issuer, execute unit and register file.
interface exec_if;
  import exec_pkg::*;

  logic             issue_valid;
  logic             issue_ready;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SEL_W-1:0] dest;
  logic [WIDTH-1:0] wb_data;
  logic [SEL_W-1:0] wb_dest;
  logic             wb_en;
  logic             flag_z;
  logic             flag_c;
  logic             err;

  modport master (
    output issue_valid, op, a, b, dest,
    input  issue_ready, wb_data, wb_dest, wb_en, flag_z, flag_c, err
  );

  modport slave (
    input  issue_valid, op, a, b, dest,
    output issue_ready, wb_data, wb_dest, wb_en, flag_z, flag_c, err
  );

endinterface

// File: rtl/exec_alu.sv
// Combinational ALU for the single-cycle opcodes, with zero/carry generation.
module exec_alu
  import exec_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_c,
  output logic             carry_c,
  output logic             zero_c,
  output logic             legal_c
);

  logic [WIDTH:0]         sum;
  logic [SHAMT_W-1:0]     shamt;

  assign sum   = (WIDTH+1)'(a) + (WIDTH+1)'(b);
  assign shamt = b[SHAMT_W-1:0];

  // Result mux; MUL and the unused codes are flagged not-legal here, the top decides.
  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    legal_c = 1'b1;
    case (op)
      OP_MOV: res_c = a;
      OP_ADD: begin
        res_c   = sum[WIDTH-1:0];
        carry_c = sum[WIDTH];
      end
      OP_SUB: begin
        res_c   = a - b;
        carry_c = (a < b);
      end
      OP_AND: res_c = a & b;
      OP_OR:  res_c = a | b;
      OP_XOR: res_c = a ^ b;
      OP_NOT: res_c = ~a;
      OP_SHL: res_c = a << shamt;
      OP_SHR: res_c = a >> shamt;
      default: legal_c = 1'b0;
    endcase
    zero_c = (res_c == '0);
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: issue handshake, write-back registers and iterative shift-add multiplier.
// Define EXEC_MUL_EN to build the multiplier; otherwise opcode 9 is illegal.
module exec_unit
  import exec_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  exec_if.slave   bus
);

  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic [SEL_W-1:0] wb_dest_q, wb_dest_d;
  logic             wb_en_q,   wb_en_d;
  logic             flag_z_q,  flag_z_d;
  logic             flag_c_q,  flag_c_d;
  logic             err_q,     err_d;
  logic             ready_q,   ready_d;
  logic             accept;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_z;
  logic             alu_legal;

`ifdef EXEC_MUL_EN
  state_e           state_q,   state_d;
  logic [WIDTH-1:0] mcand_q,   mcand_d;
  logic [WIDTH-1:0] mplier_q,  mplier_d;
  logic [WIDTH-1:0] acc_q,     acc_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [SEL_W-1:0] dest_pend_q, dest_pend_d;
  logic [WIDTH-1:0] acc_add;
`endif

  exec_alu u_alu (
    .op      (bus.op),
    .a       (bus.a),
    .b       (bus.b),
    .res_c   (alu_res),
    .carry_c (alu_c),
    .zero_c  (alu_z),
    .legal_c (alu_legal)
  );

  assign accept = bus.issue_valid & ready_q;

  // Next-state: write-back on legal single-cycle ops, err on illegal ones, multiply sequencing.
  always_comb begin
    wb_data_d = wb_data_q;
    wb_dest_d = wb_dest_q;
    wb_en_d   = 1'b0;
    flag_z_d  = flag_z_q;
    flag_c_d  = flag_c_q;
    err_d     = 1'b0;
    ready_d   = ready_q;
`ifdef EXEC_MUL_EN
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    dest_pend_d = dest_pend_q;
    acc_add     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.op == OP_MUL) begin
            mcand_d     = bus.a;
            mplier_d    = bus.b;
            acc_d       = '0;
            cnt_d       = '0;
            dest_pend_d = bus.dest;
            ready_d     = 1'b0;
            state_d     = MUL;
          end else if (alu_legal) begin
            wb_data_d = alu_res;
            wb_dest_d = bus.dest;
            wb_en_d   = 1'b1;
            flag_z_d  = alu_z;
            flag_c_d  = alu_c;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d    = acc_add;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        // Last iteration: publish the product in the same edge.
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          wb_data_d = acc_add;
          wb_dest_d = dest_pend_q;
          wb_en_d   = 1'b1;
          flag_z_d  = (acc_add == '0);
          flag_c_d  = 1'b0;
          ready_d   = 1'b1;
          state_d   = IDLE;
        end
      end
    endcase
`else
    if (accept) begin
      if (alu_legal) begin
        wb_data_d = alu_res;
        wb_dest_d = bus.dest;
        wb_en_d   = 1'b1;
        flag_z_d  = alu_z;
        flag_c_d  = alu_c;
      end else begin
        err_d = 1'b1;
      end
    end
`endif
  end

  // Write-back and handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_data_q <= '0;
      wb_dest_q <= '0;
      wb_en_q   <= 1'b0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      wb_data_q <= wb_data_d;
      wb_dest_q <= wb_dest_d;
      wb_en_q   <= wb_en_d;
      flag_z_q  <= flag_z_d;
      flag_c_q  <= flag_c_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
    end
  end

`ifdef EXEC_MUL_EN
  // Multiplier state; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      dest_pend_q <= '0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      dest_pend_q <= dest_pend_d;
    end
  end
`endif

  assign bus.issue_ready = ready_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_dest     = wb_dest_q;
  assign bus.wb_en       = wb_en_q;
  assign bus.flag_z      = flag_z_q;
  assign bus.flag_c      = flag_c_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed scenarios plus random ops against an arithmetic model.
module tb_exec_unit;
  import exec_pkg::*;

`ifdef EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  exec_if bus ();

  exec_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_data;
  logic [3:0]  exp_dest;
  logic        exp_z;
  logic        exp_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input bit wb, input bit er, input bit rdy);
    chk({tag, " wb_en"},   32'(bus.wb_en),       32'(wb));
    chk({tag, " wb_data"}, 32'(bus.wb_data),     32'(exp_data));
    chk({tag, " wb_dest"}, 32'(bus.wb_dest),     32'(exp_dest));
    chk({tag, " flag_z"},  32'(bus.flag_z),      32'(exp_z));
    chk({tag, " flag_c"},  32'(bus.flag_c),      32'(exp_c));
    chk({tag, " err"},     32'(bus.err),         32'(er));
    chk({tag, " ready"},   32'(bus.issue_ready), 32'(rdy));
  endtask

  // Reference behaviour from the opcode table, using plain unsigned arithmetic.
  function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                output bit legal, output bit is_mul,
                                output logic [15:0] r, output bit c);
    int unsigned ua;
    int unsigned ub;
    int unsigned sh;
    ua = 32'(a);
    ub = 32'(b);
    sh = ub % 16;
    legal  = 1'b1;
    is_mul = 1'b0;
    r      = 16'h0;
    c      = 1'b0;
    case (op)
      4'd0: r = a;
      4'd1: begin r = 16'((ua + ub) % 65536); c = (ua + ub) > 65535; end
      4'd2: begin r = 16'((ua + 65536 - ub) % 65536); c = (ua < ub); end
      4'd3: r = a & b;
      4'd4: r = a | b;
      4'd5: r = a ^ b;
      4'd6: r = ~a;
      4'd7: r = 16'((ua << sh) % 65536);
      4'd8: r = 16'(ua >> sh);
      4'd9: begin
        if (MUL_EN) begin
          is_mul = 1'b1;
          r = 16'((ua * ub) % 65536);
        end else begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase
  endfunction

  // Issue one op from an idle unit and check its full outcome.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] dest);
    bit          legal;
    bit          is_mul;
    logic [15:0] r;
    bit          c;
    int          lat;
    model(op, a, b, legal, is_mul, r, c);
    chk({tag, " pre_ready"}, 32'(bus.issue_ready), 32'd1);
    bus.issue_valid = 1'b1;
    bus.op   = op;
    bus.a    = a;
    bus.b    = b;
    bus.dest = dest;
    tick();
    bus.issue_valid = 1'b0;
    if (!is_mul) begin
      if (legal) begin
        exp_data = r;
        exp_dest = dest;
        exp_z    = (r == 16'h0);
        exp_c    = c;
      end
      check_outs(tag, legal, !legal, 1'b1);
    end else begin
      check_outs({tag, " accept"}, 1'b0, 1'b0, 1'b0);
      lat = 0;
      while (!bus.wb_en && lat < 20) begin
        tick();
        lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'd16);
      exp_data = r;
      exp_dest = dest;
      exp_z    = (r == 16'h0);
      exp_c    = 1'b0;
      check_outs({tag, " wb"}, 1'b1, 1'b0, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.issue_valid = 1'b0;
    bus.op   = 4'd0;
    bus.a    = 16'h0;
    bus.b    = 16'h0;
    bus.dest = 4'd0;
    exp_data = 16'h0;
    exp_dest = 4'd0;
    exp_z    = 1'b0;
    exp_c    = 1'b0;

    #3;
    check_outs("reset", 1'b0, 1'b0, 1'b1);
    #9 rst = 1'b0;
    tick();
    check_outs("post_reset", 1'b0, 1'b0, 1'b1);

    // ADD wrap to zero with carry out
    do_op("add_wrap", 4'd1, 16'hFFFF, 16'h0001, 4'd3);
    chk("add_wrap const_data", 32'(bus.wb_data), 32'h0);
    chk("add_wrap const_zc",   32'({bus.flag_z, bus.flag_c}), 32'b11);

    // SUB then AND back to back
    bus.issue_valid = 1'b1;
    bus.op = 4'd2; bus.a = 16'd5; bus.b = 16'd7; bus.dest = 4'd4;
    tick();
    exp_data = 16'hFFFE; exp_dest = 4'd4; exp_z = 1'b0; exp_c = 1'b1;
    check_outs("b2b_sub", 1'b1, 1'b0, 1'b1);
    bus.op = 4'd3; bus.a = 16'hF0F0; bus.b = 16'h0FF0; bus.dest = 4'd6;
    tick();
    exp_data = 16'h00F0; exp_dest = 4'd6; exp_z = 1'b0; exp_c = 1'b0;
    check_outs("b2b_and", 1'b1, 1'b0, 1'b1);
    bus.issue_valid = 1'b0;
    tick();
    check_outs("b2b_idle", 1'b0, 1'b0, 1'b1);

    // Illegal opcode: one-cycle err, nothing else moves
    do_op("illegal12", 4'd12, 16'h1234, 16'h5678, 4'd7);
    tick();
    check_outs("illegal12_after", 1'b0, 1'b0, 1'b1);

`ifdef EXEC_MUL_EN
    // MUL with a second op held valid while busy
    bus.issue_valid = 1'b1;
    bus.op = 4'd9; bus.a = 16'd300; bus.b = 16'd200; bus.dest = 4'd9;
    tick();
    check_outs("mul_accept", 1'b0, 1'b0, 1'b0);
    bus.op = 4'd1; bus.a = 16'd3; bus.b = 16'd4; bus.dest = 4'd5;
    for (int k = 1; k < 16; k++) begin
      tick();
      chk("mul_busy wb_en", 32'(bus.wb_en), 32'd0);
      chk("mul_busy ready", 32'(bus.issue_ready), 32'd0);
    end
    tick();
    exp_data = 16'hEA60; exp_dest = 4'd9; exp_z = 1'b0; exp_c = 1'b0;
    check_outs("mul_wb", 1'b1, 1'b0, 1'b1);
    tick();
    exp_data = 16'd7; exp_dest = 4'd5; exp_z = 1'b0; exp_c = 1'b0;
    check_outs("held_add", 1'b1, 1'b0, 1'b1);
    bus.issue_valid = 1'b0;
    tick();
    check_outs("held_idle", 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a multiply
    begin
      int seen;
      bus.issue_valid = 1'b1;
      bus.op = 4'd9; bus.a = 16'd1234; bus.b = 16'd77; bus.dest = 4'd2;
      tick();
      bus.issue_valid = 1'b0;
      repeat (7) tick();
      rst = 1'b1;
      #1;
      exp_data = 16'h0; exp_dest = 4'd0; exp_z = 1'b0; exp_c = 1'b0;
      check_outs("mul_reset", 1'b0, 1'b0, 1'b1);
      #2 rst = 1'b0;
      seen = 0;
      repeat (20) begin
        tick();
        if (bus.wb_en) seen++;
      end
      chk("mul_reset no_wb", 32'(seen), 32'd0);
      check_outs("mul_reset_after", 1'b0, 1'b0, 1'b1);
    end
`else
    // Without the multiplier, opcode 9 is just illegal
    do_op("mul_off", 4'd9, 16'd300, 16'd200, 4'd9);
    repeat (5) begin
      tick();
      chk("mul_off ready", 32'(bus.issue_ready), 32'd1);
      chk("mul_off wb_en", 32'(bus.wb_en), 32'd0);
    end
`endif

    // Shift boundaries
    do_op("shl15", 4'd7, 16'h0003, 16'h00FF, 4'd1);
    do_op("shr0",  4'd8, 16'h8001, 16'h0010, 4'd2);

    // Random ops, occasionally separated by idle cycles
    for (int i = 0; i < 80; i++) begin
      do_op("rand", 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
            4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin
        tick();
        check_outs("rand_gap", 1'b0, 1'b0, 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
